mux_share_arb: RTL and testbench
================================

# mux_share_arb

Sequencing arbiter that time-shares the team's 4-bit 2:1 mux datapath between two requesters, A and B. It grants the mux to one requester at a time for a fixed hold window and drives the mux select. It registers the selected nibble with a valid flag and pulses a per-requester done when a window completes. It sits in front of the mux and owns its select line; no other block drives it.

## Interface
- HOLD, 4, number of cycles per grant window; legal range 1..(2^CNT_W).
- CNT_W, 3, hold-counter width.

- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_a  input  1  requester A wants the mux; level, held until done_a or withdrawn.
- req_b  input  1  requester B wants the mux; same rules as req_a.
- data_a  input  4  A's nibble, routed to mux input a.
- data_b  input  4  B's nibble, routed to mux input b.
- mux_sel  output  1  select driven to the shared mux; 0 = A, 1 = B.
- gnt_a  output  1  A currently owns the mux.
- gnt_b  output  1  B currently owns the mux.
- done_a  output  1  one-cycle pulse in A's final window cycle.
- done_b  output  1  one-cycle pulse in B's final window cycle.
- data_out  output  4  registered selected nibble.
- data_valid  output  1  data_out holds a granted sample.

## Operation
- State machine states:
  - IDLE: no grant; mux_sel = 0.
  - GNT_A: gnt_a = 1; mux_sel = 0.
  - GNT_B: gnt_b = 1; mux_sel = 1.
- gnt_a, gnt_b and mux_sel are decoded from state only, never from inputs. gnt_a and gnt_b are never high together.
- last_gnt register records the most recent winner. It resets to B, so A wins the first tie.
- IDLE transitions:
  - only req_a → GNT_A.
  - only req_b → GNT_B.
  - both → the requester that is not last_gnt.
  - neither → stay in IDLE.
- On entering a grant state: cnt loads 0 and last_gnt updates.
- In a grant state, cnt increments each cycle.
- done_x = gnt_x AND (cnt == HOLD-1), decoded combinationally.
- End of window (cnt == HOLD-1) transitions, in priority order:
  - other requester's req high → other grant state, no idle bubble.
  - else own req still high → same grant state again, cnt reloads 0.
  - else → IDLE.
- Withdrawal: if the owner's req drops mid-window (cnt < HOLD-1), the next state is IDLE. No done pulse is issued, and the other requester is not granted in that same transition.
- HOLD = 1: every grant cycle is also the done cycle. With both requesting, grants alternate A, B, A, … every cycle.
- Datapath register:
  - data_out ← data_a when state = GNT_A.
  - data_out ← data_b when state = GNT_B.
  - In IDLE, data_out holds its value and data_valid ← 0.
  - data_valid ← gnt_a OR gnt_b.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, cnt = 0, last_gnt = B.
  - mux_sel = 0; gnt_a, gnt_b, done_a, done_b = 0.
  - data_out = 4'h0, data_valid = 0.
- Grant latency: a req sampled high in IDLE at edge k gives a grant from edge k (visible in cycle k+1).
- Window length: exactly HOLD cycles of gnt_x. done_x is high in the last of those cycles.
- Data latency: data_out and data_valid lag the grant by one cycle. A window of HOLD grant cycles yields HOLD consecutive data_valid cycles.
- Requesters must hold data stable only while they are granted.
- Back-to-back handover A→B: gnt_a falls and gnt_b rises on the same edge. mux_sel toggles on that edge. data_valid stays continuously high across the boundary.
- Reset asserted mid-window: everything clears asynchronously, with no done pulse. After release, arbitration restarts as from power-up.

## Test plan
- Reset: drive rst_n = 0 mid-window with HOLD = 4 → all outputs 0 within the reset cycle; after release with req_a = req_b = 1, A is granted first.
- Single requester: req_a = 1 for one window, data_a = 4'h5, HOLD = 4 → gnt_a for 4 cycles, done_a in cycle 4, data_out = 5 with data_valid for 4 cycles lagging by 1, then IDLE.
- Contention: req_a = req_b = 1 held, data_a = 4'hA, data_b = 4'h3 → grants alternate A, B, A every 4 cycles with no idle gap; data_out stream is A×4, 3×4, A×4; mux_sel toggles every 4 cycles.
- Withdrawal: A granted, req_a dropped at cnt = 1 while req_b = 1 → one IDLE cycle, no done_a, then GNT_B.
- Same requester re-grant: req_a held high, req_b low, 3 windows → gnt_a continuous for 12 cycles, done_a pulses at cycles 4, 8 and 12.
- HOLD = 1 build, both requesting → gnt alternates every cycle, done pulses every cycle, gnt_a and gnt_b never high together (assert checks this throughout all tests).

Source files
------------

// File: rtl/mux_share_arb.sv
// Purpose : time-shares the 4-bit 2:1 mux between requesters A and B in fixed
//           HOLD-cycle grant windows; owns mux_sel and registers the chosen nibble.
// Latency : grant one cycle after a sampled req; data_out/data_valid lag the grant by one cycle.
// Backpressure: none; requesters hold req (level) until done_x, or drop it to withdraw.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_a/req_b          level requests
//   data_a/data_b        nibbles on the two mux inputs
//   mux_sel              0 = A, 1 = B; decoded from state only
//   gnt_a/gnt_b          current owner, never both high
//   done_a/done_b        pulse in the final cycle of the owner's window
//   data_out/data_valid  registered selected nibble and its valid flag
module mux_share_arb #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    output logic       mux_sel,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic [3:0] data_out,
    output logic       data_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    // last_gnt: 0 = A won most recently, 1 = B won most recently
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic [3:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;

    logic             win_end;
    logic             take_a;
    logic             take_b;
    logic             go_idle;
    logic [3:0]       mux_out;

    // Outputs are pure state decodes so they cannot glitch with the requests.
    assign gnt_a      = (state_q == GNT_A);
    assign gnt_b      = (state_q == GNT_B);
    assign mux_sel    = gnt_b;
    assign win_end    = (cnt_q == CNT_LAST);
    assign done_a     = gnt_a && win_end;
    assign done_b     = gnt_b && win_end;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

    // The shared mux itself: select is ours, inputs belong to the requesters.
    assign mux_out = mux_sel ? data_b : data_a;

    always_comb begin
        take_a  = 1'b0;
        take_b  = 1'b0;
        go_idle = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (req_a && (!req_b || last_gnt_q)) begin
                    take_a = 1'b1;
                end else if (req_b) begin
                    take_b = 1'b1;
                end
            end
            GNT_A: begin
                if (win_end) begin
                    // Hand straight to the other side when it waits; no idle bubble.
                    if (req_b) begin
                        take_b = 1'b1;
                    end else if (req_a) begin
                        take_a = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (!req_a) begin
                    // Mid-window withdrawal always passes through IDLE.
                    go_idle = 1'b1;
                end
            end
            GNT_B: begin
                if (win_end) begin
                    if (req_a) begin
                        take_a = 1'b1;
                    end else if (req_b) begin
                        take_b = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (!req_b) begin
                    go_idle = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;

        if (take_a) begin
            state_d    = GNT_A;
            cnt_d      = '0;
            last_gnt_d = 1'b0;
        end else if (take_b) begin
            state_d    = GNT_B;
            cnt_d      = '0;
            last_gnt_d = 1'b1;
        end else if (go_idle) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        data_valid_d = gnt_a || gnt_b;
        data_out_d   = data_out_q;
        if (gnt_a || gnt_b) begin
            data_out_d = mux_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_gnt_q   <= 1'b1;
            data_out_q   <= 4'h0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_gnt_q   <= last_gnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

endmodule

// File: tb/tb_mux_share_arb.sv
// Purpose : scoreboard bench for mux_share_arb, HOLD=4 instance plus a HOLD=1 instance.
// Latency : expected grant/data streams are queued ahead of stimulus and popped by monitors.
// Backpressure: n/a; monitors sample on the falling edge.
module tb_mux_share_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       req_a, req_b;
    logic [3:0] data_a, data_b;
    logic       mux_sel, gnt_a, gnt_b, done_a, done_b, data_valid;
    logic [3:0] data_out;

    logic       r1_a, r1_b;
    logic [3:0] d1_a, d1_b;
    logic       sel1, g1_a, g1_b, dn1_a, dn1_b, v1;
    logic [3:0] q1;

    int errors = 0;
    int checks = 0;

    // grant entries are {mux_sel, gnt_a, gnt_b, done_a, done_b}
    logic [4:0] gq0[$];
    logic [4:0] gq1[$];
    logic [3:0] dq0[$];
    logic [3:0] dq1[$];

    mux_share_arb #(.HOLD(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
        .mux_sel(mux_sel), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .done_a(done_a), .done_b(done_b),
        .data_out(data_out), .data_valid(data_valid)
    );

    mux_share_arb #(.HOLD(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(r1_a), .req_b(r1_b), .data_a(d1_a), .data_b(d1_b),
        .mux_sel(sel1), .gnt_a(g1_a), .gnt_b(g1_b),
        .done_a(dn1_a), .done_b(dn1_b),
        .data_out(q1), .data_valid(v1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic win0(input bit b, input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            gq0.push_back({b, !b, b, (i == 3) && !b, (i == 3) && b});
            dq0.push_back(d);
        end
    endtask

    task automatic win1(input bit b, input logic [3:0] d);
        gq1.push_back({b, !b, b, !b, b});
        dq1.push_back(d);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("mutex0", {31'd0, gnt_a & gnt_b}, 32'd0);
            if (mux_sel | gnt_a | gnt_b | done_a | done_b) begin
                if (gq0.size() == 0) check("gnt0_unexpected", {27'd0, mux_sel, gnt_a, gnt_b, done_a, done_b}, 32'd0);
                else check("gnt0", {27'd0, mux_sel, gnt_a, gnt_b, done_a, done_b}, {27'd0, gq0.pop_front()});
            end
            if (data_valid) begin
                if (dq0.size() == 0) check("data0_unexpected", {31'd0, data_valid}, 32'd0);
                else check("data0", {28'd0, data_out}, {28'd0, dq0.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("mutex1", {31'd0, g1_a & g1_b}, 32'd0);
            if (sel1 | g1_a | g1_b | dn1_a | dn1_b) begin
                if (gq1.size() == 0) check("gnt1_unexpected", {27'd0, sel1, g1_a, g1_b, dn1_a, dn1_b}, 32'd0);
                else check("gnt1", {27'd0, sel1, g1_a, g1_b, dn1_a, dn1_b}, {27'd0, gq1.pop_front()});
            end
            if (v1) begin
                if (dq1.size() == 0) check("data1_unexpected", {31'd0, v1}, 32'd0);
                else check("data1", {28'd0, q1}, {28'd0, dq1.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; data_a = 4'h0; data_b = 4'h0;
        r1_a = 1'b0; r1_b = 1'b0; d1_a = 4'h0; d1_b = 4'h0;

        #3;
        check("reset0", {22'd0, mux_sel, gnt_a, gnt_b, done_a, done_b, data_valid, data_out}, 32'd0);
        check("reset1", {22'd0, sel1, g1_a, g1_b, dn1_a, dn1_b, v1, q1}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1);

        // Reset in the middle of an A window: one grant cycle reaches the monitor.
        gq0.push_back(5'b01000);
        req_a = 1'b1; data_a = 4'hD;
        tick(1);
        check("mid_gnt_a", {31'd0, gnt_a}, 32'd1);
        tick(1);
        check("mid_data", {27'd0, data_valid, data_out}, {27'd0, 1'b1, 4'hD});
        #2;
        rst_n = 1'b0;
        req_b = 1'b1; data_a = 4'hA; data_b = 4'h3;
        #1;
        check("mid_reset_clear", {22'd0, mux_sel, gnt_a, gnt_b, done_a, done_b, data_valid, data_out}, 32'd0);
        #3 rst_n = 1'b1;

        // Contention from reset: A first, then B, then A, no idle gap.
        win0(1'b0, 4'hA);
        win0(1'b1, 4'h3);
        win0(1'b0, 4'hA);
        tick(1);
        check("cont_first_a", {30'd0, mux_sel, gnt_a}, 32'd1);
        tick(4);
        check("cont_handover", {28'd0, mux_sel, gnt_b, data_valid, 1'b0}, 32'hE);
        check("cont_last_a_data", {28'd0, data_out}, 32'hA);
        tick(4);
        check("cont_back_to_a", {30'd0, mux_sel, gnt_a}, 32'd1);
        check("cont_last_b_data", {27'd0, data_valid, data_out}, {27'd0, 1'b1, 4'h3});
        tick(3);
        req_a = 1'b0; req_b = 1'b0;
        tick(2);

        // Single requester window.
        win0(1'b0, 4'h5);
        req_a = 1'b1; data_a = 4'h5;
        tick(4);
        check("single_done", {30'd0, gnt_a, done_a}, 32'd3);
        req_a = 1'b0;
        tick(1);
        check("single_idle", {27'd0, gnt_a, data_valid, data_out}, {27'd0, 1'b0, 1'b1, 4'h5});
        tick(1);
        check("single_hold", {27'd0, data_valid, data_out}, {27'd0, 1'b0, 4'h5});

        // Same requester re-granted for three windows.
        win0(1'b0, 4'hC);
        win0(1'b0, 4'hC);
        win0(1'b0, 4'hC);
        req_a = 1'b1; data_a = 4'hC;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            check("regrant", {30'd0, gnt_a, done_a}, {30'd0, 1'b1, (i % 4) == 0});
        end
        req_a = 1'b0;
        tick(2);

        // Withdrawal at cnt=1 while B waits.
        gq0.push_back(5'b01000);
        gq0.push_back(5'b01000);
        dq0.push_back(4'h9);
        dq0.push_back(4'h9);
        win0(1'b1, 4'h6);
        req_a = 1'b1; data_a = 4'h9;
        tick(1);
        req_b = 1'b1; data_b = 4'h6;
        tick(1);
        req_a = 1'b0;
        tick(1);
        check("withdraw_idle", {28'd0, gnt_a, gnt_b, done_a, data_valid}, 32'd1);
        tick(1);
        check("withdraw_gnt_b", {30'd0, gnt_b, mux_sel}, 32'd3);
        tick(3);
        req_b = 1'b0;
        tick(2);

        // HOLD = 1: alternate every cycle, each cycle is a done cycle.
        for (int i = 0; i < 3; i++) begin
            win1(1'b0, 4'h7);
            win1(1'b1, 4'hE);
        end
        r1_a = 1'b1; r1_b = 1'b1; d1_a = 4'h7; d1_b = 4'hE;
        tick(1);
        check("h1_first", {28'd0, g1_a, dn1_a, g1_b, sel1}, 32'hC);
        tick(1);
        check("h1_second", {28'd0, g1_a, dn1_a, g1_b, sel1}, 32'h3);
        tick(4);
        r1_a = 1'b0; r1_b = 1'b0;
        tick(2);

        check("gq0_drained", gq0.size(), 32'd0);
        check("dq0_drained", dq0.size(), 32'd0);
        check("gq1_drained", gq1.size(), 32'd0);
        check("dq1_drained", dq1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
